// File: rtl/cpu_defs_pkg.sv
// Shared control definitions: opcodes, T-step states, strobe bundle.
// CTRL_MULDIV_EN enables sequencing of mul/div; otherwise they run as nop.
package cpu_defs_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [2:0] RS_GRA = 3'b100;
  localparam logic [2:0] RS_GRB = 3'b010;
  localparam logic [2:0] RS_GRC = 3'b001;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_LD, C_LDI, C_ST,
    C_REG, C_IMM, C_MULDIV, C_HALT
  } cls_t;

  typedef struct packed {
    logic           pc_out;
    logic           zlo_out;
    logic           mdr_out;
    logic           r_out;
    logic           ba_out;
    logic           c_out;
    logic           mar_in;
    logic           z_in;
    logic           pc_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           r_in;
    logic           inc_pc;
    logic           read;
    logic           write;
    logic [2:0]     rsel;
    logic [OPW-1:0] alu_op;
    logic           run;
  } strobe_t;

  function automatic cls_t op_class(input logic [OPW-1:0] op);
    cls_t c;
    c = C_NOP;
    unique case (1'b1)
      (op == OP_LD):                   c = C_LD;
      (op == OP_LDI):                  c = C_LDI;
      (op == OP_ST):                   c = C_ST;
      (op >= OP_ADD && op <= OP_ROL):  c = C_REG;
      (op >= OP_ADDI && op <= OP_ORI): c = C_IMM;
`ifdef CTRL_MULDIV_EN
      (op == OP_MUL || op == OP_DIV):  c = C_MULDIV;
`endif
      (op == OP_HALT):                 c = C_HALT;
      default:                         c = C_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/step_decoder.sv
// Combinational (T-step, instruction class) to datapath strobe decode.
// CTRL_MULDIV_EN only affects which classes reach this block.
module step_decoder
  import cpu_defs_pkg::*;
(
  input  state_t         state,
  input  cls_t           cls,
  input  logic [OPW-1:0] op,
  output strobe_t        s
);

  always_comb begin
    s     = '0;
    s.run = (state != S_RST) && (state != S_HALT);
    unique case (state)
      S_T0: begin
        s.pc_out = 1'b1;
        s.mar_in = 1'b1;
        s.inc_pc = 1'b1;
        s.z_in   = 1'b1;
      end
      S_T1: begin
        s.zlo_out = 1'b1;
        s.pc_in   = 1'b1;
        s.read    = 1'b1;
        s.mdr_in  = 1'b1;
      end
      S_T2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      S_T3: begin
        s.y_in = 1'b1;
        unique case (cls)
          C_LD, C_LDI, C_ST: begin
            s.rsel   = RS_GRB;
            s.ba_out = 1'b1;
          end
          C_MULDIV: begin
            s.rsel  = RS_GRA;
            s.r_out = 1'b1;
          end
          default: begin
            s.rsel  = RS_GRB;
            s.r_out = 1'b1;
          end
        endcase
      end
      S_T4: begin
        s.z_in   = 1'b1;
        s.alu_op = op;
        unique case (cls)
          C_LD, C_LDI, C_ST: begin
            s.c_out  = 1'b1;
            s.alu_op = OP_ADD;
          end
          C_IMM:    s.c_out = 1'b1;
          C_MULDIV: begin
            s.rsel  = RS_GRB;
            s.r_out = 1'b1;
          end
          default: begin
            s.rsel  = RS_GRC;
            s.r_out = 1'b1;
          end
        endcase
      end
      S_T5: begin
        s.zlo_out = 1'b1;
        if (cls == C_LD || cls == C_ST) begin
          s.mar_in = 1'b1;
        end else begin
          s.rsel = RS_GRA;
          s.r_in = 1'b1;
        end
      end
      S_T6: begin
        s.mdr_in = 1'b1;
        if (cls == C_ST) begin
          s.rsel  = RS_GRA;
          s.r_out = 1'b1;
        end else begin
          s.read = 1'b1;
        end
      end
      S_T7: begin
        if (cls == C_ST) begin
          s.write = 1'b1;
        end else begin
          s.mdr_out = 1'b1;
          s.rsel    = RS_GRA;
          s.r_in    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-step sequencer: state register, opcode latch, stall logic.
// CTRL_MULDIV_EN adds mul/div sequencing with the ALU_done stall.
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [31:0]    IR,
  input  logic           Mem_ready,
  input  logic           ALU_done,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Rin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [2:0]     Rsel,
  output logic [OPW-1:0] ALU_op,
  output logic           Run
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  cls_t           cls_q, cls_ir;
  state_t         done_st;
  strobe_t        s;
  logic           unused_ir;

  // Register fields are consumed by the datapath, not here.
  assign unused_ir = ^IR[26:0];

  assign cls_q   = op_class(op_q);
  assign cls_ir  = op_class(IR[31:27]);
  assign done_st = Stop ? S_HALT : S_T0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  if (Mem_ready) state_d = S_T2;
      S_T2: begin
        op_d = IR[31:27];
        unique case (cls_ir)
          C_NOP:   state_d = done_st;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_T3;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: begin
        if (cls_q != C_MULDIV || ALU_done) state_d = S_T5;
      end
      S_T5: begin
        if (cls_q == C_LD || cls_q == C_ST) state_d = S_T6;
        else                                state_d = done_st;
      end
      S_T6: begin
        if (cls_q == C_ST || Mem_ready) state_d = S_T7;
      end
      S_T7: begin
        if (cls_q == C_LD || Mem_ready) state_d = done_st;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  step_decoder u_dec (
    .state (state_q),
    .cls   (cls_q),
    .op    (op_q),
    .s     (s)
  );

  assign PCout   = s.pc_out;
  assign Zlowout = s.zlo_out;
  assign MDRout  = s.mdr_out;
  assign Rout    = s.r_out;
  assign BAout   = s.ba_out;
  assign Cout    = s.c_out;
  assign MARin   = s.mar_in;
  assign Zin     = s.z_in;
  assign PCin    = s.pc_in;
  assign MDRin   = s.mdr_in;
  assign IRin    = s.ir_in;
  assign Yin     = s.y_in;
  assign Rin     = s.r_in;
  assign IncPC   = s.inc_pc;
  assign Read    = s.read;
  assign Write   = s.write;
  assign Rsel    = s.rsel;
  assign ALU_op  = s.alu_op;
  assign Run     = s.run;

endmodule

// File: doc/control_unit.md
# control_unit
Hardwired control sequencer that sits directly upstream of `DataPath`. It decodes the instruction held in IR and, one T-step per clock, asserts the datapath strobes (bus drivers, register enables, memory read/write, ALU opcode) that the datapath consumes. Execution follows a fetch/decode/execute T0–T7 sequence, with stalls on memory and multicycle-ALU handshakes.
## Interface
- `OPW`, 5: opcode / ALU_op width (IR[31:27]).
- `Clock` in 1: sole clock; all state changes on rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `IR` in 32: instruction register contents; opcode is IR[31:27].
- `Mem_ready` in 1: memory completed the current Read/Write this cycle.
- `ALU_done` in 1: multicycle ALU result valid (mul/div only).
- `Stop` in 1: halt request, sampled at instruction boundaries.
- `PCout`, `Zlowout`, `MDRout`, `Rout`, `BAout`, `Cout` out 1 each: bus drivers.
- `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `Rin` out 1 each: register load enables.
- `IncPC` out 1: ALU computes PC+1.
- `Read` out 1: memory read / MDR takes memory data.
- `Write` out 1: memory write from MDR/MAR.
- `Rsel` out 3: one-hot {Gra, Grb, Grc} register-field select.
- `ALU_op` out OPW: ALU operation, meaningful only while `Zin`=1.
- `Run` out 1: 1 while executing; 0 in HALT.
## Operation
- Moore FSM; states RST, T0–T7, HALT. Outputs decode from the state register and latched opcode only; no input-to-output combinational path.
- Opcodes: 00000 ld, 00001 ldi, 00010 st, 00011–01010 add/sub/and/or/shr/shl/ror/rol, 01011–01101 addi/andi/ori, 01110 mul, 01111 div, 11010 nop, 11011 halt. Any other opcode executes as nop.
- Fetch: T0 PCout,MARin,IncPC,Zin. T1 Zlowout,PCin,Read,MDRin. T2 MDRout,IRin. Opcode latched at the end of T2.
- Reg ALU: T3 Grb,Rout,Yin. T4 Grc,Rout,Zin,ALU_op=opcode. T5 Zlowout,Gra,Rin → T0.
- Imm ALU: as reg ALU, except T4 uses Cout instead of Grc,Rout.
- ldi: T3 Grb,BAout,Yin. T4 Cout,Zin,ALU_op=add. T5 Zlowout,Gra,Rin.
- ld: as ldi through T4. T5 Zlowout,MARin. T6 Read,MDRin. T7 MDRout,Gra,Rin.
- st: as ld through T5. T6 Gra,Rout,MDRin. T7 Write.
- mul/div: T3 Gra,Rout,Yin. T4 Grb,Rout,Zin,ALU_op=opcode. T5 Zlowout,Gra,Rin.
- nop: T2 → T0. halt: T2 → HALT.
- HALT: all strobes 0, Run=0. Exit only via Resetn.
## Timing
- Reset: async assertion forces state RST. All outputs 0, Run=0, ALU_op=0. Applies from any state, including mid-stall.
- RST → T0 on the first rising edge after Resetn deasserts. Run=1 from T0 onward.
- One T-step per clock. Add: 6 cycles; ld/st: 8 cycles + stalls.
- Memory stall: in T1, T6 (ld) and T7 (st), the state holds with outputs unchanged until `Mem_ready`=1 is sampled. The state advances on that edge.
- ALU stall: T4 of mul/div holds until `ALU_done`=1.
- `Stop` is sampled only at the edge where the next state would be T0. If Stop=1, go to HALT instead; the current instruction always completes.
- Simultaneous Mem_ready and Stop at an instruction's last stall: complete the step, then go to HALT.
## Configuration
- `CTRL_MULDIV_EN` defined: mul/div are sequenced as above, with the ALU_done stall.
- Not defined: mul/div execute as nop and ALU_done is ignored.
## Structure
- Shared package `cpu_defs_pkg`: opcode constants, state enumeration, `OPW`.
- Sub-module `step_decoder`: combinational (state, opcode) → strobe vector. The top level holds the state register, opcode latch and stall logic.
## Test plan
- IR=0x28918000 (and R1,R2,R3), Mem_ready=1 → T0–T5 strobes exactly as listed; at T4 ALU_op=00101; back to T0 after 6 cycles.
- ld with Mem_ready held low 3 cycles at T6 → Read,MDRin held 4 cycles; T7 asserts MDRout,Gra,Rin once.
- Resetn pulsed low during st T6 → all outputs 0 immediately; T0 on the first edge after release.
- halt (0xD8000000) → HALT, Run=0; further Mem_ready and Stop activity has no effect.
- Stop=1 raised during add T3 → add completes T5, then HALT; no T0 occurs.
- mul (0x70000000) with ALU_done delayed 2 cycles: with CTRL_MULDIV_EN, T4 lasts 3 cycles; without it, the instruction behaves as nop (T2 → T0).
